// File: rtl/plot_scheduler_pkg.sv
// Shared widths, client indices and FSM encoding for the plot scheduler.
// No logic; latency n/a.
// Backpressure n/a.
package plot_scheduler_pkg;

    localparam int X_BITES     = 8;
    localparam int Y_BITES     = 7;
    localparam int COLOR_BITES = 3;

    typedef logic [1:0] client_t;

    localparam client_t RECT   = 2'd0;
    localparam client_t TEXT   = 2'd1;
    localparam client_t CURSOR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Successor in the 0 -> 1 -> 2 -> 0 ring; anything out of range maps to RECT.
    function automatic client_t next_client(input client_t c);
        return (c >= CURSOR) ? RECT : client_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/plot_scheduler_rr_pick3.sv
// Round-robin picker over three requesters, searching from last+1 upward.
// Purely combinational, zero latency.
// No backpressure; valid is low when no request is pending.
module rr_pick3
    import plot_scheduler_pkg::*;
(
    input  logic [2:0] req,
    input  client_t    last,
    output client_t    winner,
    output logic       valid
);

    client_t c0;
    client_t c1;
    client_t c2;

    always_comb begin
        c0     = next_client(last);
        c1     = next_client(c0);
        c2     = next_client(c1);
        winner = RECT;
        valid  = 1'b0;
        if (req[c0]) begin
            winner = c0;
            valid  = 1'b1;
        end else if (req[c1]) begin
            winner = c1;
            valid  = 1'b1;
        end else if (req[c2]) begin
            winner = c2;
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Arbitrates three pixel renderers onto one framebuffer port with a per-job watchdog.
// Grant one edge after req in IDLE; pixels appear one cycle after the winner drives them.
// No backpressure on pixels; a job ends on the winner's done or on watchdog expiry.
module plot_scheduler
    import plot_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TMO_BITS       = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [2:0]               req,
    input  logic [2:0]               done,
    input  logic [3*X_BITES-1:0]     in_x,
    input  logic [3*Y_BITES-1:0]     in_y,
    input  logic [3*COLOR_BITES-1:0] in_color,
    input  logic [2:0]               in_plot,
    output logic [2:0]               grant,
    output logic [X_BITES-1:0]       out_x,
    output logic [Y_BITES-1:0]       out_y,
    output logic [COLOR_BITES-1:0]   out_color,
    output logic                     plot,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam logic [TMO_BITS-1:0] WDOG_LIMIT = TMO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_BITS-1:0] WDOG_MAX   = '1;

    state_t              state;
    state_t              state_nxt;
    client_t             last;
    client_t             win_nxt;
    client_t             pick;
    logic                pick_vld;
    logic [TMO_BITS-1:0] wdog;
    logic                tmo_set;
    logic [2:0]          grant_nxt;

    rr_pick3 u_rr_pick3 (
        .req    (req),
        .last   (last),
        .winner (pick),
        .valid  (pick_vld)
    );

    // last doubles as the current job's owner: it is rewritten only on IDLE->GRANT.
    always_comb begin
        state_nxt = state;
        tmo_set   = 1'b0;
        win_nxt   = last;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_GRANT;
                    win_nxt   = pick;
                end
            end
            ST_GRANT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (done[last]) begin
                    state_nxt = ST_RELEASE;
                end else if (wdog >= WDOG_LIMIT) begin
                    state_nxt = ST_RELEASE;
                    tmo_set   = 1'b1;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        grant_nxt = '0;
        if (state_nxt == ST_GRANT || state_nxt == ST_RUN) begin
            grant_nxt = 3'b001 << win_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            last        <= CURSOR;
            grant       <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            last        <= win_nxt;
            grant       <= grant_nxt;
            timeout_err <= timeout_err | tmo_set;
            if (state == ST_IDLE && state_nxt == ST_GRANT) begin
                wdog <= '0;
            end else if (state == ST_RUN && wdog != WDOG_MAX) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_x     <= '0;
            out_y     <= '0;
            out_color <= '0;
            plot      <= 1'b0;
        end else if (state == ST_RUN) begin
            out_x     <= in_x[X_BITES*last +: X_BITES];
            out_y     <= in_y[Y_BITES*last +: Y_BITES];
            out_color <= in_color[COLOR_BITES*last +: COLOR_BITES];
            plot      <= in_plot[last];
        end else begin
            plot      <= 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_plot_scheduler.sv
// Randomized scoreboard bench for plot_scheduler with a queue-based reference model.
module tb_plot_scheduler;

    localparam int TMO = 12;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [23:0] in_x;
    logic [20:0] in_y;
    logic [8:0]  in_color;
    logic [2:0]  in_plot;
    logic [2:0]  grant;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_color;
    logic        plot;
    logic        busy;
    logic        timeout_err;

    plot_scheduler #(.TIMEOUT_CYCLES(TMO), .TMO_BITS(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .done        (done),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_color    (in_color),
        .in_plot     (in_plot),
        .grant       (grant),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_color   (out_color),
        .plot        (plot),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int plot_cnt = 0;
    int m_last = 2;
    bit m_tmo = 1'b0;
    logic [2:0]  exp_grant[$];
    logic [17:0] exp_pix[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_model(input logic [2:0] r, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [17:0] pix_of(input int w);
        return {in_x[8*w +: 8], in_y[7*w +: 7], in_color[3*w +: 3]};
    endfunction

    task automatic randomize_pix();
        in_x     = 24'($urandom);
        in_y     = 21'($urandom);
        in_color = 9'($urandom);
        in_plot  = 3'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        randomize_pix();
    endtask

    // Scoreboard monitor: pops an expectation for every grant start and plot pulse.
    logic [2:0] prev_grant = '0;
    always @(negedge clock) begin
        if (!resetn) begin
            prev_grant = '0;
        end else begin
            if (grant != 3'b000 && prev_grant == 3'b000) begin
                if (exp_grant.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got %0h expected none", grant);
                end else begin
                    check("mon_grant", 32'(grant), 32'(exp_grant.pop_front()));
                end
            end
            prev_grant = grant;
            if (plot) begin
                plot_cnt++;
                if (exp_pix.size() == 0) begin
                    total++; bad++;
                    $display("FAIL plot_unexpected: got %0h expected none", {out_x, out_y, out_color});
                end else begin
                    check("mon_pixel", 32'({out_x, out_y, out_color}), 32'(exp_pix.pop_front()));
                end
            end
        end
    end

    // Starts in an IDLE cycle; done_at > TMO means the winner never signals done.
    task automatic run_job(input logic [2:0] r, input int done_at, input bit solid_plot);
        int w;
        int nrun;
        logic [2:0] oh;
        check("idle_grant", 32'(grant), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        req = r;
        w = rr_model(r, m_last);
        m_last = w;
        oh = 3'b001 << w;
        exp_grant.push_back(oh);
        step();
        check("grant_phase", 32'(grant), 32'(oh));
        check("grant_busy", 32'(busy), 32'(1));
        req  = 3'($urandom);
        done = 3'($urandom);
        nrun = (done_at <= TMO) ? done_at : TMO;
        for (int c = 1; c <= nrun; c++) begin
            step();
            check("run_grant", 32'(grant), 32'(oh));
            req  = 3'($urandom);
            done = 3'($urandom) & ~oh;
            if (c == done_at) done = done | oh;
            if (solid_plot) in_plot[w] = (c != done_at);
            if (in_plot[w]) exp_pix.push_back(pix_of(w));
        end
        step();
        if (done_at > TMO) m_tmo = 1'b1;
        check("release_grant", 32'(grant), 32'(0));
        check("release_busy", 32'(busy), 32'(1));
        check("timeout_err", 32'(timeout_err), 32'(m_tmo));
        done = '0;
        req  = '0;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("gap_grant", 32'(grant), 32'(0));
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_plot", 32'(plot), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tmo", 32'(timeout_err), 32'(0));
        check("rst_xyc", 32'({out_x, out_y, out_color}), 32'(0));
        exp_pix.delete();
        exp_grant.delete();
        m_last = 2;
        m_tmo  = 1'b0;
        req    = '0;
        done   = '0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic abort_job(input logic [2:0] r);
        int w;
        w = rr_model(r, m_last);
        m_last = w;
        exp_grant.push_back(3'b001 << w);
        req = r;
        step();
        step();
        done    = '0;
        in_plot = 3'b111;
        exp_pix.push_back(pix_of(w));
        step();
        check("abort_plot_live", 32'(plot), 32'(1));
        apply_reset();
    endtask

    initial begin
        int p0;
        resetn = 1'b0;
        req    = '0;
        done   = '0;
        randomize_pix();
        apply_reset();
        step();

        p0 = plot_cnt;
        run_job(3'b001, 11, 1'b1);
        check("ten_plots", 32'(plot_cnt - p0), 32'(10));
        check("busy_after_done", 32'(busy), 32'(0));

        for (int i = 0; i < 4; i++) run_job(3'b111, 1, 1'b0);

        run_job(3'b010, TMO, 1'b0);
        run_job(3'b100, TMO + 1, 1'b0);
        run_job(3'b011, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_job(3'($urandom_range(1, 7)), int'($urandom_range(1, TMO + 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        abort_job(3'b110);
        step();
        run_job(3'b111, 2, 1'b0);
        check("post_reset_owner", 32'(m_last), 32'(0));

        idle(3);
        check("pix_queue_empty", 32'(exp_pix.size()), 32'(0));
        check("grant_queue_empty", 32'(exp_grant.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
